seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_scan_driver.sv | 154 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for a 4-digit common-anode
// 7-segment display. Each digit slot starts with an anode-off guard interval.
// A per-frame input snapshot keeps every frame consistent.
// Optional macro SEG7_BLINK_EN adds per-digit blinking driven by blink_mask.
// When the macro is not defined, blink_mask is accepted but has no effect.
module seg7_scan_driver #(
   parameter int unsigned DIGIT_CYCLES = 100000,
   parameter int unsigned DEAD_CYCLES  = 1000,
   parameter int unsigned BLINK_CYCLES = 25000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] digits,
   input  logic [3:0]  dp_mask,
   input  logic        lz_en,
   input  logic [3:0]  blink_mask,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an,
   output logic        frame_done
);

   localparam int unsigned   CW       = $clog2(DIGIT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYCLES);

   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic [15:0]   snap_digits;
   logic [3:0]    snap_dp;
   logic          snap_lz;
   logic          slot_last;
   logic          frame_start;
   logic          in_dead;
   logic [3:0]    code;
   logic [6:0]    seg_dec;
   logic [3:0]    lz_blank;
   logic [6:0]    seg_next;
   logic          dp_next;
   logic          blink_hit;

   assign slot_last   = (cnt == CNT_LAST);
   assign frame_start = (idx == 2'd0) && (cnt == '0);
   assign in_dead     = (cnt < CNT_DEAD);

`ifdef SEG7_BLINK_EN
   localparam int unsigned   BW         = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

   logic [BW-1:0] blink_cnt;
   logic          blink_phase;
   logic [3:0]    snap_blink;

   // Free-running blink timebase; phase flips once per half-period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt   <= blink_cnt + 1'b1;
      end
   end

   assign blink_hit = blink_phase & snap_blink[idx];
`else
   logic unused_blink;

   assign unused_blink = ^blink_mask;
   assign blink_hit    = 1'b0;
`endif

   // Slot counter and digit index; index advances when the slot wraps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         idx <= 2'd0;
      end else if (slot_last) begin
         cnt <= '0;
         idx <= idx + 2'd1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Capture all display inputs once per frame, at the first cycle of digit 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap_digits <= 16'hFFFF;
         snap_dp     <= '0;
         snap_lz     <= 1'b0;
`ifdef SEG7_BLINK_EN
         snap_blink  <= '0;
`endif
      end else if (frame_start) begin
         snap_digits <= digits;
         snap_dp     <= dp_mask;
         snap_lz     <= lz_en;
`ifdef SEG7_BLINK_EN
         snap_blink  <= blink_mask;
`endif
      end
   end

   // Decode the current digit from the snapshot, with leading-zero and blink blanking.
   always_comb begin
      code = snap_digits[{idx, 2'b00} +: 4];
      case (code)
         4'd0:    seg_dec = 7'b1000000;
         4'd1:    seg_dec = 7'b1111001;
         4'd2:    seg_dec = 7'b0100100;
         4'd3:    seg_dec = 7'b0110000;
         4'd4:    seg_dec = 7'b0011001;
         4'd5:    seg_dec = 7'b0010010;
         4'd6:    seg_dec = 7'b0000010;
         4'd7:    seg_dec = 7'b1111000;
         4'd8:    seg_dec = 7'b0000000;
         4'd9:    seg_dec = 7'b0010000;
         4'd10:   seg_dec = 7'b0111111;
         default: seg_dec = 7'b1111111;
      endcase
      // Blanking ripples down from the leftmost digit; digit 0 always shows.
      lz_blank[3] = snap_lz     & (snap_digits[15:12] == 4'd0);
      lz_blank[2] = lz_blank[3] & (snap_digits[11:8]  == 4'd0);
      lz_blank[1] = lz_blank[2] & (snap_digits[7:4]   == 4'd0);
      lz_blank[0] = 1'b0;
      seg_next = (lz_blank[idx] | blink_hit) ? 7'b1111111 : seg_dec;
      dp_next  = blink_hit ? 1'b1 : ~snap_dp[idx];
   end

   // Registered display outputs and end-of-frame pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an         <= 4'b1111;
         seg        <= 7'b1111111;
         dp         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= (idx == 2'd3) && slot_last;
         if (in_dead) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
         end else begin
            an  <= ~(4'b0001 << idx);
            seg <= seg_next;
            dp  <= dp_next;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver with short timing parameters.
// A cycle model pushes the expected registered outputs at every clock edge.
// A negedge monitor pops each expected entry and compares it with the DUT.
// Scenario tasks add fixed-value checks taken directly from the decode table.
module tb_seg7_scan_driver;

   localparam int DIGIT = 8;
   localparam int DEAD  = 2;
   localparam int BLINK = 64;
`ifdef SEG7_BLINK_EN
   localparam bit BLINK_ON = 1'b1;
`else
   localparam bit BLINK_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] digits = 16'h0000;
   logic [3:0]  dp_mask = 4'b0000;
   logic        lz_en = 1'b0;
   logic [3:0]  blink_mask = 4'b0000;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_done;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       fd;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   sb_on  = 1'b0;

   int          m_cnt   = 0;
   logic [1:0]  m_idx   = 2'd0;
   logic [15:0] m_d     = 16'hFFFF;
   logic [3:0]  m_dp    = 4'b0000;
   logic        m_lz    = 1'b0;
   logic [3:0]  m_bl    = 4'b0000;
   int          m_bcnt  = 0;
   logic        m_phase = 1'b0;

   seg7_scan_driver #(
      .DIGIT_CYCLES(DIGIT),
      .DEAD_CYCLES (DEAD),
      .BLINK_CYCLES(BLINK)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .digits    (digits),
      .dp_mask   (dp_mask),
      .lz_en     (lz_en),
      .blink_mask(blink_mask),
      .seg       (seg),
      .dp        (dp),
      .an        (an),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] ref_seg(input logic [3:0] c);
      case (c)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         4'd10:   return 7'b0111111;
         default: return 7'b1111111;
      endcase
   endfunction

   // Expected registered outputs produced from the model state before an edge.
   function automatic exp_t model_out();
      exp_t e;
      logic b3, b2, b1;
      logic [3:0] lzb;
      e.fd = (m_idx == 2'd3) && (m_cnt == DIGIT - 1);
      if (m_cnt < DEAD) begin
         e.an  = 4'b1111;
         e.seg = 7'b1111111;
         e.dp  = 1'b1;
      end else begin
         b3  = m_lz && (m_d[15:12] == 4'd0);
         b2  = b3 && (m_d[11:8] == 4'd0);
         b1  = b2 && (m_d[7:4] == 4'd0);
         lzb = {b3, b2, b1, 1'b0};
         e.an  = ~(4'b0001 << m_idx);
         e.seg = lzb[m_idx] ? 7'b1111111 : ref_seg(m_d[{m_idx, 2'b00} +: 4]);
         e.dp  = ~m_dp[m_idx];
         if (m_phase && m_bl[m_idx]) begin
            e.seg = 7'b1111111;
            e.dp  = 1'b1;
         end
      end
      return e;
   endfunction

   // Reference model: push expectation, then advance model state.
   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_cnt = 0; m_idx = 2'd0; m_d = 16'hFFFF; m_dp = 4'b0000;
         m_lz = 1'b0; m_bl = 4'b0000; m_bcnt = 0; m_phase = 1'b0;
         exp_q.delete();
      end else begin
         exp_q.push_back(model_out());
         if (m_idx == 2'd0 && m_cnt == 0) begin
            m_d = digits; m_dp = dp_mask; m_lz = lz_en; m_bl = blink_mask;
         end
         if (m_cnt == DIGIT - 1) begin
            m_cnt = 0;
            m_idx = m_idx + 2'd1;
         end else begin
            m_cnt = m_cnt + 1;
         end
         if (BLINK_ON) begin
            if (m_bcnt == BLINK - 1) begin
               m_bcnt  = 0;
               m_phase = ~m_phase;
            end else begin
               m_bcnt = m_bcnt + 1;
            end
         end
      end
   end

   // Scoreboard monitor: one expected entry per cycle out of reset.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (sb_on && !rst) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got no expected entry at %0t, required one", $time);
         end else begin
            e = exp_q.pop_front();
            if ({an, seg, dp, frame_done} !== e) begin
               errors++;
               $display("FAIL scoreboard: got an=%b seg=%b dp=%b fd=%b, expected an=%b seg=%b dp=%b fd=%b at %0t",
                        an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd, $time);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic wait_frame_start();
      int n = 0;
      while (!(m_idx == 2'd0 && m_cnt == 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 100) begin
         errors++;
         $display("FAIL frame_sync: got no frame start after %0d cycles, expected within 100", n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; digits = 16'h1234; dp_mask = 4'b0000; lz_en = 1'b0; blink_mask = 4'b0000;
      repeat (3) @(negedge clk);
      checks++;
      if ({an, seg, dp, frame_done} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_outputs: got %b, expected %b", {an, seg, dp, frame_done},
                  {4'b1111, 7'b1111111, 1'b1, 1'b0});
      end
      #2 rst = 1'b0;
      sb_on = 1'b1;
   endtask

   task automatic test_scan();
      logic [27:0] lits = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
      logic [11:0] got, want;
      int fd_cnt = 0;
      int act0   = 0;
      wait_frame_start();
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         if (frame_done) fd_cnt++;
         if (an == 4'b1110) act0++;
         for (int d = 0; d < 4; d++) begin
            if (k == 8*d + 3 || k == 32 + 8*d + 3) begin
               got  = {an, seg, dp};
               want = {~(4'b0001 << d), 7'(lits >> (7*d)), 1'b1};
               checks++;
               if (got !== want) begin
                  errors++;
                  $display("FAIL scan_digit%0d: got %b, expected %b", d, got, want);
               end
            end
            if (k == 8*d + 1) begin
               checks++;
               if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
                  errors++;
                  $display("FAIL scan_dead%0d: got %b, expected %b", d, {an, seg, dp},
                           {4'b1111, 7'b1111111, 1'b1});
               end
            end
         end
         if (k == 32 || k == 64) begin
            checks++;
            if (frame_done !== 1'b1) begin
               errors++;
               $display("FAIL frame_done_pulse: got %b at cycle %0d, expected 1", frame_done, k);
            end
         end
      end
      checks++;
      if (fd_cnt != 2) begin
         errors++;
         $display("FAIL frame_done_count: got %0d, expected 2", fd_cnt);
      end
      checks++;
      if (act0 != 12) begin
         errors++;
         $display("FAIL digit0_active_cycles: got %0d, expected 12", act0);
      end
   endtask

   task automatic test_lz();
      logic [27:0] lits_a = {7'b1111111, 7'b1111111, 7'b0011001, 7'b1000000};
      logic [27:0] lits_b = {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000};
      logic [6:0]  want;
      wait_frame_start();
      digits = 16'h0040; lz_en = 1'b1;
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         for (int d = 0; d < 4; d++) begin
            if (k == 8*d + 3 || k == 32 + 8*d + 3) begin
               want = (k < 32) ? 7'(lits_a >> (7*d)) : 7'(lits_b >> (7*d));
               checks++;
               if (seg !== want || an !== ~(4'b0001 << d)) begin
                  errors++;
                  $display("FAIL lz_digit%0d_k%0d: got an=%b seg=%b, expected seg=%b", d, k, an, seg, want);
               end
            end
         end
         if (k == 32) digits = 16'h0000;
      end
      lz_en = 1'b0;
   endtask

   task automatic test_snapshot();
      wait_frame_start();
      digits = 16'h1111;
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         for (int d = 0; d < 4; d++) begin
            if (k == 8*d + 3 || k == 32 + 8*d + 3) begin
               checks++;
               if (seg !== ((k < 32) ? 7'b1111001 : 7'b0100100)) begin
                  errors++;
                  $display("FAIL snapshot_digit%0d_k%0d: got %b, expected %b", d, k, seg,
                           (k < 32) ? 7'b1111001 : 7'b0100100);
               end
            end
         end
         if (k == 20) digits = 16'h2222;
      end
   endtask

   task automatic test_dp_codes();
      logic [27:0] lits_a = {7'b1111111, 7'b0111111, 7'b1111111, 7'b0111111};
      logic [27:0] lits_b = {7'b1111111, 7'b1111111, 7'b1111111, 7'b0010010};
      logic [3:0]  dp_a = 4'b1010;
      logic [3:0]  dp_b = 4'b0111;
      logic [7:0]  want;
      wait_frame_start();
      digits = 16'hDADA; dp_mask = 4'b0101; lz_en = 1'b0;
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         for (int d = 0; d < 4; d++) begin
            if (k == 8*d + 3 || k == 32 + 8*d + 3) begin
               want = (k < 32) ? {7'(lits_a >> (7*d)), ((dp_a >> d) & 4'b0001) != 4'b0000}
                               : {7'(lits_b >> (7*d)), ((dp_b >> d) & 4'b0001) != 4'b0000};
               checks++;
               if ({seg, dp} !== want) begin
                  errors++;
                  $display("FAIL dp_codes_digit%0d_k%0d: got %b, expected %b", d, k, {seg, dp}, want);
               end
            end
            if (k == 8*d + 2) begin
               checks++;
               if (dp !== 1'b1) begin
                  errors++;
                  $display("FAIL dp_dead%0d: got %b, expected 1", d, dp);
               end
            end
         end
         if (k == 32) begin
            digits = 16'h0005; dp_mask = 4'b1000; lz_en = 1'b1;
         end
      end
      dp_mask = 4'b0000; lz_en = 1'b0;
   endtask

   task automatic test_blink();
      logic       ph;
      logic [6:0] want;
      digits = 16'h1234; blink_mask = 4'b0001;
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      #2 rst = 1'b0;
      for (int k = 1; k <= 136; k++) begin
         @(negedge clk);
         ph = BLINK_ON && ((((k - 1) / BLINK) % 2) == 1);
         if (k == 3 || k == 35 || k == 67 || k == 99 || k == 131) begin
            want = ph ? 7'b1111111 : 7'b0011001;
            checks++;
            if ({an, seg, dp} !== {4'b1110, want, 1'b1}) begin
               errors++;
               $display("FAIL blink_digit0_k%0d: got %b, expected %b", k, {an, seg, dp}, {4'b1110, want, 1'b1});
            end
         end
         if (k == 75 || k == 107) begin
            checks++;
            if ({an, seg} !== {4'b1101, 7'b0110000}) begin
               errors++;
               $display("FAIL blink_digit1_k%0d: got %b, expected %b", k, {an, seg}, {4'b1101, 7'b0110000});
            end
         end
      end
      blink_mask = 4'b0000;
   endtask

   task automatic test_reset_mid();
      wait_frame_start();
      digits = 16'h1234;
      repeat (21) @(negedge clk);
      checks++;
      if (an !== 4'b1011) begin
         errors++;
         $display("FAIL mid_reset_precondition: got an=%b, expected 1011", an);
      end
      #2 rst = 1'b1;
      digits = 16'h5678;
      #1;
      checks++;
      if ({an, seg, dp, frame_done} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL mid_reset_outputs: got %b, expected %b", {an, seg, dp, frame_done},
                  {4'b1111, 7'b1111111, 1'b1, 1'b0});
      end
      @(negedge clk);
      #2 rst = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (k == 1) begin
            checks++;
            if (an !== 4'b1111) begin
               errors++;
               $display("FAIL mid_reset_restart_dead: got an=%b, expected 1111", an);
            end
         end
         if (k == 3) begin
            checks++;
            if ({an, seg} !== {4'b1110, 7'b0000000}) begin
               errors++;
               $display("FAIL mid_reset_digit0: got %b, expected %b", {an, seg}, {4'b1110, 7'b0000000});
            end
         end
         if (k == 11) begin
            checks++;
            if ({an, seg} !== {4'b1101, 7'b1111000}) begin
               errors++;
               $display("FAIL mid_reset_digit1: got %b, expected %b", {an, seg}, {4'b1101, 7'b1111000});
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_lz();
      test_snapshot();
      test_dp_codes();
      test_blink();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
